// File: rtl/mux_scan_n1.sv
// mux_scan_n1: registered N:1 data mux with a manual-select mode and an
// auto-scan mode that walks every channel once, in order.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode         0 = manual select, 1 = auto-scan (looked at only in IDLE)
//   select       manual channel index, qualified by sel_valid
//   start        scan start strobe
//   stall        holds the scan in place (no beat emitted)
//   abort        terminates a scan in progress
//   in_data      packed channels, channel k at [k*WIDTH +: WIDTH]
//   out_data     selected data, holds when out_valid is low
//   out_valid    one-cycle qualifier per output beat
//   out_channel  channel index carried by out_data
//   busy         high while scanning
//   done         pulse on the final scan beat
//   err          pulse on an out-of-range manual select
module mux_scan_n1 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic                      sel_valid,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      abort,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_channel,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] idx_c;
  logic [WIDTH-1:0] mux_c;
  logic             sel_ok_c;

  // Channel index feeding the mux: scan counter, 0 for a scan start, or select.
  always_comb begin
    idx_c = cnt_q;
    if (state_q == IDLE) begin
      idx_c = mode ? '0 : select;
    end
  end

  // Decoded mux; out-of-range indices yield zero and are never registered.
  always_comb begin
    mux_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx_c == SEL_W'(k)) begin
        mux_c = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_ok_c = (32'(select) < CHANNELS);

  // Next-state and output decode; pulses default low, data/channel hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mode) begin
          if (start) begin
            valid_d = 1'b1;
            data_d  = mux_c;
            chan_d  = '0;
            // A single-channel scan completes on its first beat.
            if (LAST_IDX == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = SCAN;
              cnt_d   = SEL_W'(1);
            end
          end
        end else if (sel_valid) begin
          if (sel_ok_c) begin
            valid_d = 1'b1;
            data_d  = mux_c;
            chan_d  = select;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!stall) begin
          valid_d = 1'b1;
          data_d  = mux_c;
          chan_d  = cnt_q;
          if (cnt_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == SCAN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_channel = chan_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/mux_scan_n1.md
MUX_SCAN_N1 -- requirements
Module: mux_scan_n1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 16, number of input channels (legal range 1..2**SEL_W).
REQ-003 SHALL have parameter SEL_W, default 8, channel index width.
REQ-004 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have mode  input  1  0 = manual select, 1 = auto-scan; sampled only in IDLE.
REQ-007 SHALL have select  input  SEL_W  manual channel index.
REQ-008 SHALL have sel_valid  input  1  manual request strobe.
REQ-009 SHALL have start  input  1  scan start strobe.
REQ-010 SHALL have stall  input  1  scan hold; freezes the scan counter.
REQ-011 SHALL have abort  input  1  terminates a scan.
REQ-012 SHALL have in_data  input  CHANNELS*WIDTH  packed inputs; channel k = bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have out_data  output  WIDTH  registered selected data.
REQ-014 SHALL have out_valid  output  1  one-cycle qualifier per output beat.
REQ-015 SHALL have out_channel  output  SEL_W  index of the channel in out_data.
REQ-016 SHALL have busy  output  1  high while in SCAN.
REQ-017 SHALL have done  output  1  one-cycle pulse coincident with the final scan beat.
REQ-018 SHALL have err  output  1  one-cycle pulse on an out-of-range manual select.

Function
REQ-019 SHALL implement FSM states IDLE and SCAN; all outputs registered.
REQ-020 IDLE, mode=0, sel_valid=1, select<CHANNELS: next edge out_data=channel[select], out_channel=select, out_valid=1 (latency 1).
REQ-021 IDLE, mode=0, sel_valid=1, select>=CHANNELS: next edge err=1, out_valid=0, out_data/out_channel unchanged.
REQ-022 IDLE, mode=1, start=1: next edge state=SCAN, out_data=channel[0], out_channel=0, out_valid=1, internal counter=1.
REQ-023 SCAN, stall=0: each edge emits channel[counter] with out_valid=1 and increments the counter; beats are back-to-back.
REQ-024 SCAN, stall=1: counter held, out_valid=0, out_data/out_channel held; resumes at the held index when stall falls.
REQ-025 The beat carrying channel CHANNELS-1 SHALL assert done=1 on the same cycle; the FSM returns to IDLE on that edge, with no counter wrap.
REQ-026 CHANNELS=1: start yields a single beat with out_valid=1 and done=1; busy stays 0.
REQ-027 SCAN, abort=1: next edge state=IDLE, out_valid=0, done=0; abort has priority over stall; abort in IDLE is ignored.
REQ-028 In SCAN, start, sel_valid and mode changes SHALL be ignored.
REQ-029 IDLE with start=1 and sel_valid=1: mode decides; mode=1 serves start, mode=0 serves sel_valid.
REQ-030 out_valid, done and err SHALL be single-cycle pulses; out_data holds its last value whenever out_valid=0.
REQ-031 in_data SHALL be sampled at the edge that produces the beat; no buffering of earlier values.
REQ-032 busy SHALL be 1 exactly while the state is SCAN (registered).

Reset
REQ-033 On rst_n low, the block SHALL immediately (asynchronously) force state=IDLE, counter=0, out_data=0, out_channel=0, out_valid=0, busy=0, done=0, err=0.
REQ-034 Reset asserted mid-scan SHALL discard the scan; after release, the block SHALL wait for a new start.

Verification
REQ-035 WIDTH=32, CHANNELS=16, in[k]=32'h7000_0000+k; mode=0, sel_valid with select=0..15 one per cycle -> out_data=32'h7000_0000+select one cycle later, out_valid=1 each cycle.
REQ-036 mode=0, select=8'd16 -> err=1 for one cycle, out_valid=0, out_data unchanged.
REQ-037 mode=1, start pulse -> 16 consecutive beats 32'h7000_0000..32'h7000_000F, out_channel 0..15, done=1 only on channel 15, busy=1 on cycles with channel 0..14.
REQ-038 Scan with stall=1 for 3 cycles after channel 4 -> out_valid=0 for 3 cycles with out_data holding 32'h7000_0004, then channel 5; 16 valid beats total.
REQ-039 abort during the channel 7 beat -> IDLE next cycle, no done; a new start restarts from channel 0.
REQ-040 rst_n low during channel 10 of a scan -> all outputs 0 immediately; after release, with no start, out_valid stays 0.
